// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg: shared state encoding, memory depth and I/O addresses for mem_loader
package mem_loader_pkg;
   localparam int MEM_DEPTH = 64;
   localparam logic [0:0] LOAD = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;
   localparam logic [5:0] IO_IN_ADDR  = 6'h3E;
   localparam logic [5:0] IO_OUT_ADDR = 6'h3F;
endpackage

// File: rtl/ram64x8.sv
// ram64x8: 64x8 RAM, one synchronous write port, one combinational read port, no reset
module ram64x8 (
   input  logic       clk,
   input  logic       we,
   input  logic [5:0] waddr,
   input  logic [7:0] wdata,
   input  logic [5:0] raddr,
   output logic [7:0] rdata
);
   logic [7:0] mem_q [0:63];
   always_ff @(posedge clk)
      if (we) mem_q[waddr] <= wdata;
   assign rdata = mem_q[raddr];
endmodule

// File: rtl/mem_loader.sv
// mem_loader: byte loader for a processor RAM with LOAD/RUN control; MEM_LOADER_IO_EN maps gpio at 6'h3E/6'h3F
module mem_loader
   import mem_loader_pkg::*;
#(
   parameter int DEPTH = MEM_DEPTH
) (
   input  logic       clk,
   input  logic       clr,
   input  logic [5:0] cpu_addr,
   input  logic       cpu_we,
   input  logic [7:0] cpu_wdata,
   output logic [7:0] cpu_rdata,
   output logic       cpu_clr_n,
   input  logic       ld_valid,
   input  logic [7:0] ld_data,
   input  logic       ld_last,
   output logic       ld_ready,
   input  logic       ld_start,
   input  logic       run_req,
   input  logic [7:0] gpio_in,
   output logic [7:0] gpio_out
);
   logic [0:0] state_q, state_d;
   logic [5:0] wptr_q, wptr_d;
   logic       clr_n_q, clr_n_d;
   logic       accept, last_word, cpu_wr, io_hit, ram_we;
   logic [7:0] ram_rdata;
   assign ld_ready  = state_q == LOAD;
   assign cpu_clr_n = clr_n_q;
   assign accept    = ld_valid & ld_ready;
   assign last_word = wptr_q == 6'(DEPTH - 1);
   assign cpu_wr    = state_q == RUN & cpu_we & ~ld_start;
   always_comb begin
      state_d = state_q;
      wptr_d  = wptr_q;
      if (state_q == LOAD) begin
         wptr_d  = accept && !last_word ? wptr_q + 6'd1 : wptr_q;
         state_d = (accept && (ld_last || last_word)) || run_req ? RUN : LOAD;
      end else if (ld_start) begin
         state_d = LOAD;
         wptr_d  = '0;
      end
      clr_n_d = state_d == RUN;
   end
   always_ff @(posedge clk)
      if (clr) begin
         state_q <= LOAD;
         wptr_q  <= '0;
         clr_n_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         clr_n_q <= clr_n_d;
      end
   // loader and processor writes are exclusive because they live in different states
   assign ram_we = ~clr & (accept | (cpu_wr & ~io_hit));
   ram64x8 u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (accept ? wptr_q : cpu_addr),
      .wdata (accept ? ld_data : cpu_wdata),
      .raddr (cpu_addr),
      .rdata (ram_rdata)
   );
`ifdef MEM_LOADER_IO_EN
   logic [7:0] sync1_q, sync2_q, gpio_q, gpio_d;
   assign io_hit    = cpu_addr == IO_IN_ADDR || cpu_addr == IO_OUT_ADDR;
   assign gpio_d    = cpu_wr && cpu_addr == IO_OUT_ADDR ? cpu_wdata : gpio_q;
   assign cpu_rdata = cpu_addr == IO_IN_ADDR ? sync2_q : cpu_addr == IO_OUT_ADDR ? gpio_q : ram_rdata;
   assign gpio_out  = gpio_q;
   always_ff @(posedge clk)
      if (clr) begin
         sync1_q <= '0;
         sync2_q <= '0;
         gpio_q  <= '0;
      end else begin
         sync1_q <= gpio_in;
         sync2_q <= sync1_q;
         gpio_q  <= gpio_d;
      end
`else
   logic unused_gpio;
   assign unused_gpio = ^gpio_in;
   assign io_hit      = 1'b0;
   assign cpu_rdata   = ram_rdata;
   assign gpio_out    = 8'h00;
`endif
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: directed self-checking bench for mem_loader
module tb_mem_loader;
   logic       clk = 1'b0;
   logic       clr, cpu_we, ld_valid, ld_last, ld_start, run_req;
   logic [5:0] cpu_addr;
   logic [7:0] cpu_wdata, ld_data, gpio_in;
   logic [7:0] cpu_rdata, gpio_out;
   logic       cpu_clr_n, ld_ready;
   int         passed = 0;
   int         total = 0;
   always #5 clk = ~clk;
   mem_loader dut (
      .clk(clk), .clr(clr), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_clr_n(cpu_clr_n), .ld_valid(ld_valid), .ld_data(ld_data),
      .ld_last(ld_last), .ld_ready(ld_ready), .ld_start(ld_start), .run_req(run_req),
      .gpio_in(gpio_in), .gpio_out(gpio_out)
   );
   function automatic logic [7:0] b(input int i);
      return 8'(i * 7 + 3);
   endfunction
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic rd(input string tag, input logic [5:0] a, input logic [7:0] exp);
      cpu_addr = a;
      #1;
      chk(tag, cpu_rdata, exp);
   endtask
   task automatic send(input logic [7:0] d, input logic last);
      ld_valid = 1'b1;
      ld_data  = d;
      ld_last  = last;
      tick;
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask
   task automatic cwr(input logic [5:0] a, input logic [7:0] d);
      cpu_we    = 1'b1;
      cpu_addr  = a;
      cpu_wdata = d;
      tick;
      cpu_we = 1'b0;
   endtask
   initial begin
      clr = 1'b1; cpu_we = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_start = 1'b0;
      run_req = 1'b0; cpu_addr = '0; cpu_wdata = '0; ld_data = '0; gpio_in = '0;
      tick;
      tick;
      clr = 1'b0;
      chk("rst_clr_n", {7'd0, cpu_clr_n}, 8'd0);
      chk("rst_ready", {7'd0, ld_ready}, 8'd1);
      chk("rst_gpio", gpio_out, 8'h00);
      send(8'h05, 1'b0);
      send(8'h4C, 1'b0);
      chk("pre_last_clr_n", {7'd0, cpu_clr_n}, 8'd0);
      send(8'hC0, 1'b1);
      chk("last_clr_n", {7'd0, cpu_clr_n}, 8'd1);
      chk("last_ready", {7'd0, ld_ready}, 8'd0);
      rd("mem0", 6'd0, 8'h05);
      rd("mem1", 6'd1, 8'h4C);
      rd("mem2", 6'd2, 8'hC0);
      cwr(6'h10, 8'hA5);
      rd("cpu_wr_10", 6'h10, 8'hA5);
      cwr(6'h20, 8'h77);
      ld_start = 1'b1; cpu_we = 1'b1; cpu_addr = 6'h20; cpu_wdata = 8'h99;
      tick;
      ld_start = 1'b0; cpu_we = 1'b0;
      chk("abort_clr_n", {7'd0, cpu_clr_n}, 8'd0);
      chk("abort_ready", {7'd0, ld_ready}, 8'd1);
      rd("abort_no_wr", 6'h20, 8'h77);
      send(8'h11, 1'b0);
      rd("reload_at0", 6'd0, 8'h11);
      run_req = 1'b1;
      send(8'h22, 1'b0);
      run_req = 1'b0;
      chk("runreq_byte_clr_n", {7'd0, cpu_clr_n}, 8'd1);
      rd("runreq_byte", 6'd1, 8'h22);
      ld_valid = 1'b1; ld_data = 8'hEE;
      tick;
      ld_valid = 1'b0;
      rd("run_ld_ignored", 6'd2, 8'hC0);
      ld_start = 1'b1;
      tick;
      ld_start = 1'b0;
      for (int i = 0; i < 63; i++) send(b(i), 1'b0);
      chk("full_63_clr_n", {7'd0, cpu_clr_n}, 8'd0);
      send(b(63), 1'b0);
      chk("full_64_clr_n", {7'd0, cpu_clr_n}, 8'd1);
      chk("full_64_ready", {7'd0, ld_ready}, 8'd0);
      rd("full_mem0_nowrap", 6'd0, b(0));
      rd("full_mem31", 6'd31, b(31));
      rd("full_mem62", 6'd62, b(62));
`ifndef MEM_LOADER_IO_EN
      rd("full_mem63", 6'd63, b(63));
`endif
      ld_start = 1'b1;
      tick;
      ld_start = 1'b0;
      cwr(6'd40, 8'hFF);
      rd("load_cpu_we_ignored", 6'd40, b(40));
      run_req = 1'b1;
      tick;
      run_req = 1'b0;
      chk("runreq_clr_n", {7'd0, cpu_clr_n}, 8'd1);
      rd("runreq_image", 6'd0, b(0));
      cwr(6'h3F, 8'h3C);
`ifdef MEM_LOADER_IO_EN
      chk("gpio_out", gpio_out, 8'h3C);
      rd("gpio_out_rd", 6'h3F, 8'h3C);
      gpio_in = 8'h81;
      tick;
      tick;
      rd("gpio_in_sync", 6'h3E, 8'h81);
`else
      chk("gpio_out_const", gpio_out, 8'h00);
      rd("io_addr_ram", 6'h3F, 8'h3C);
`endif
      clr = 1'b1; ld_valid = 1'b1; ld_data = 8'hEE; run_req = 1'b1;
      cpu_we = 1'b1; cpu_addr = 6'd0; cpu_wdata = 8'h00;
      tick;
      clr = 1'b0; ld_valid = 1'b0; run_req = 1'b0; cpu_we = 1'b0;
      chk("clr_prio_clr_n", {7'd0, cpu_clr_n}, 8'd0);
      chk("clr_prio_ready", {7'd0, ld_ready}, 8'd1);
      chk("clr_gpio", gpio_out, 8'h00);
      rd("clr_no_cpu_wr", 6'd0, b(0));
      rd("clr_keeps_mem", 6'd16, b(16));
      run_req = 1'b1;
      tick;
      run_req = 1'b0;
      chk("retained_clr_n", {7'd0, cpu_clr_n}, 8'd1);
      rd("retained_mem1", 6'd1, b(1));
      rd("retained_mem62", 6'd62, b(62));
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter: DEPTH, default 64, number of 8-bit memory words; address width is fixed at 6 bits.
REQ-002 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-003 Port: clr  in  1  reset, synchronous and active-high.
REQ-004 Port: cpu_addr  in  6  processor memory address.
REQ-005 Port: cpu_we  in  1  processor write strobe.
REQ-006 Port: cpu_wdata  in  8  processor store data (processor data_out).
REQ-007 Port: cpu_rdata  out  8  read data to processor (processor data_in), combinational from cpu_addr.
REQ-008 Port: cpu_clr_n  out  1  registered active-low reset driven to the processor.
REQ-009 Port: ld_valid  in  1  loader byte valid.
REQ-010 Port: ld_data  in  8  loader byte.
REQ-011 Port: ld_last  in  1  marks the final loader byte; qualified by ld_valid.
REQ-012 Port: ld_ready  out  1  loader may transfer; high only in LOAD.
REQ-013 Port: ld_start  in  1  single-cycle request to abort RUN and reload.
REQ-014 Port: run_req  in  1  single-cycle request to leave LOAD without further bytes.
REQ-015 Port: gpio_in  in  8  asynchronous input port.
REQ-016 Port: gpio_out  out  8  registered output port.

Function
REQ-017 States: LOAD, RUN; a byte is accepted when ld_valid and ld_ready are both high at a rising edge.
REQ-018 LOAD: cpu_clr_n=0, ld_ready=1, each accepted byte written to mem[wptr], then wptr increments by 1.
REQ-019 LOAD->RUN at the edge that accepts a byte with ld_last=1, accepts the byte at wptr=DEPTH-1, or samples run_req=1.
REQ-020 cpu_clr_n SHALL be 1 from the same edge on which the state becomes RUN; processor leaves reset with PC=0.
REQ-021 RUN: ld_ready=0, ld_valid ignored; cpu_we=1 writes cpu_wdata to mem[cpu_addr] at the edge.
REQ-022 RUN->LOAD on ld_start=1: wptr:=0, cpu_clr_n:=0 at that edge; a cpu_we in the same cycle is discarded.
REQ-023 run_req and an accepted byte in the same cycle: byte is written, then RUN.
REQ-024 cpu_we in LOAD is ignored; wptr never wraps (exit at DEPTH-1 precedes wrap).
REQ-025 cpu_rdata = mem[cpu_addr] in both states, zero-latency read.
REQ-026 Memory contents are not cleared by clr; run_req immediately after reset runs the retained image.

Reset
REQ-027 clr=1 at an edge: state=LOAD, wptr=0, cpu_clr_n=0, ld_ready=1, gpio_out=8'h00, gpio synchroniser=0.
REQ-028 clr has priority over ld_start, run_req, ld_valid and cpu_we in the same cycle.

Configuration
REQ-029 Macro MEM_LOADER_IO_EN defined: address 6'h3E reads gpio_in through a 2-flop synchroniser (writes ignored); 6'h3F reads gpio_out and in RUN a cpu_we to it loads gpio_out, not RAM.
REQ-030 Macro undefined: 6'h3E/6'h3F are plain RAM, gpio_out is constant 8'h00, gpio_in unused.
REQ-031 Loader writes always go to RAM regardless of the macro.

Structure
REQ-032 Shared package mem_loader_pkg holds the state enum, MEM_DEPTH=64, IO_IN_ADDR=6'h3E, IO_OUT_ADDR=6'h3F.
REQ-033 One sub-module ram64x8: one synchronous write port, one combinational read port, no reset.

Verification
REQ-034 Reset, send 3 bytes 8'h05,8'h4C,8'hC0 with ld_last on third -> mem[0..2] match, cpu_clr_n rises at third accept edge, ld_ready falls.
REQ-035 Send 64 bytes without ld_last -> RUN entered at 64th accept, wptr does not wrap, mem[63] holds byte 64.
REQ-036 RUN, cpu_we=1, cpu_addr=6'h10, cpu_wdata=8'hA5 -> next cycle cpu_rdata=8'hA5 at 6'h10.
REQ-037 RUN, ld_start coincident with cpu_we to 6'h20 -> cpu_clr_n=0, mem[6'h20] unchanged, next byte lands at 0.
REQ-038 MEM_LOADER_IO_EN: write 8'h3C to 6'h3F -> gpio_out=8'h3C; gpio_in=8'h81 -> 6'h3E reads 8'h81 after 2 cycles; without macro same write lands in RAM.
REQ-039 Load image, clr, run_req -> cpu_clr_n=1 with image intact.
